// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the issue controller and the
// iterative multiply/divide stage.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  ready, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output ready, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide stage owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_q, qm_q, opb_q;
    logic             is_div_q, neg_q, rneg_q, dz_q;
    logic             done_q, dbz_q;

    logic             ready, accept, step, fin_wr;
    logic             is_md, is_sgn, sa, sb, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] addend, acc_d, qm_d;
    logic [WIDTH:0]   msum, shl, dif;
    logic             ge;
    logic [2*WIDTH-1:0] prod, prod_res;
    logic [WIDTH-1:0] quot, rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && is_md) state_d = BUSY;
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state_q == IDLE);
        accept = ready && bus.start && !bus.flush;
        step   = (state_q == BUSY) && !bus.flush && !dz_q;
        fin_wr = (state_q == FIN) && !bus.flush;
    end

    // Signed ops run on magnitudes; signs are reapplied at FIN
    always_comb begin
        is_md  = (bus.op[2] == 1'b0);
        is_sgn = ~bus.op[0];
        sa     = is_sgn & bus.a[WIDTH-1];
        sb     = is_sgn & bus.b[WIDTH-1];
        mag_a  = sa ? -bus.a : bus.a;
        mag_b  = sb ? -bus.b : bus.b;
        b_zero = (bus.b == '0);
    end

    always_comb begin
        addend = qm_q[0] ? opb_q : '0;
        msum   = {1'b0, acc_q} + {1'b0, addend};
        shl    = {acc_q, qm_q[WIDTH-1]};
        dif    = shl - {1'b0, opb_q};
        ge     = (shl >= {1'b0, opb_q});
        if (is_div_q) begin
            acc_d = ge ? dif[WIDTH-1:0] : shl[WIDTH-1:0];
            qm_d  = {qm_q[WIDTH-2:0], ge};
        end else begin
            acc_d = msum[WIDTH:1];
            qm_d  = {msum[0], qm_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_q, qm_q};
        prod_res = neg_q ? -prod : prod;
        quot     = neg_q ? -qm_q : qm_q;
        rem      = rneg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            qm_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= fin_wr;
            dbz_q  <= fin_wr & dz_q;
            if (accept && bus.op == 3'b100) hi_q <= bus.a;
            if (accept && bus.op == 3'b101) lo_q <= bus.a;
            if (accept && is_md) begin
                is_div_q <= bus.op[1];
                dz_q     <= bus.op[1] & b_zero;
                neg_q    <= sa ^ sb;
                rneg_q   <= sa;
                acc_q    <= '0;
                // divide-by-zero keeps the raw dividend for HI
                qm_q     <= (bus.op[1] & b_zero) ? bus.a : mag_a;
                opb_q    <= mag_b;
                cnt_q    <= '0;
            end
            if (step) begin
                acc_q <= acc_d;
                qm_q  <= qm_d;
            end
            if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
            if (fin_wr) begin
                if (dz_q) begin
                    hi_q <= qm_q;
                    lo_q <= '1;
                end else if (is_div_q) begin
                    hi_q <= rem;
                    lo_q <= quot;
                end else begin
                    {hi_q, lo_q} <= prod_res;
                end
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model
// checked every cycle, plus hand-computed literal results.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   cyc;
    int   e0;
    int   n_cmp;
    int   n_err;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model_res(
        input logic [2:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        model_res = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin
                p = 64'(sa * sb);
                model_res = {1'b0, p};
            end
            3'b001: begin
                p = {32'h0, a} * {32'h0, b};
                model_res = {1'b0, p};
            end
            3'b010, 3'b011: begin
                if (b == 32'h0) begin
                    model_res = {1'b1, a, 32'hFFFF_FFFF};
                end else if (op == 3'b010) begin
                    q = sa / sb;
                    r = sa % sb;
                    model_res = {1'b0, r[31:0], q[31:0]};
                end else begin
                    uq = a / b;
                    ur = a % b;
                    model_res = {1'b0, ur, uq};
                end
            end
            default: model_res = '0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_ready, m_done, m_dbz, p_dbz;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi    <= '0;
            m_lo    <= '0;
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_dbz   <= 1'b0;
            m_left  <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_left > 0) begin
                if (bus.flush) begin
                    m_left  <= 0;
                    m_ready <= 1'b1;
                end else if (m_left == 1) begin
                    m_left  <= 0;
                    m_hi    <= p_hi;
                    m_lo    <= p_lo;
                    m_dbz   <= p_dbz;
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start && !bus.flush) begin
                case (bus.op)
                    3'b100: m_hi <= bus.a;
                    3'b101: m_lo <= bus.a;
                    3'b000, 3'b001, 3'b010, 3'b011: begin
                        {p_dbz, p_hi, p_lo} <=
                            model_res(bus.op, bus.a, bus.b);
                        m_left  <= 33;
                        m_ready <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({bus.ready, bus.done, bus.div_by_zero, bus.hi, bus.lo} !==
            {m_ready, m_done, m_dbz, m_hi, m_lo}) begin
            n_err++;
            $display("FAIL model@%0d: got r%b d%b z%b hi=%h lo=%h required r%b d%b z%b hi=%h lo=%h",
                     cyc, bus.ready, bus.done, bus.div_by_zero,
                     bus.hi, bus.lo, m_ready, m_done, m_dbz, m_hi, m_lo);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic go(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #2;
        e0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done"}, 32'(seen), 32'd1);
        check({name, "_lat"}, 32'(cyc - e0), 32'd33);
    endtask

    task automatic no_done(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    logic [2:0]  vop [6];
    logic [31:0] va  [6];
    logic [31:0] vb  [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        e0    = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_done", 32'(bus.done), 32'd0);

        go(3'b100, 32'h1234_5678, 32'h0);
        check("mthi_pre", bus.hi, 32'h1234_5678);
        go(3'b000, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        check("arst_ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        no_done("arst_no_done", 40);

        go(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult");
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFF1);

        go(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu");
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        go(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done("div");
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        go(3'b011, 32'd7, 32'd2);
        wait_done("divu");
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        go(3'b011, 32'd7, 32'd0);
        wait_done("dz");
        check("dz_flag", 32'(bus.div_by_zero), 32'd1);
        check("dz_hi", bus.hi, 32'd7);
        check("dz_lo", bus.lo, 32'hFFFF_FFFF);

        go(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf");
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);
        check("ovf_dz", 32'(bus.div_by_zero), 32'd0);

        go(3'b100, 32'hCAFE_F00D, 32'h0);
        check("mthi_hi", bus.hi, 32'hCAFE_F00D);
        check("mthi_ready", 32'(bus.ready), 32'd1);
        check("mthi_done", 32'(bus.done), 32'd0);

        @(posedge clk);
        #2;
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'h55;
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("idle_flush_hi", bus.hi, 32'hCAFE_F00D);

        go(3'b110, 32'h1, 32'h2);
        check("rsv_ready", 32'(bus.ready), 32'd1);
        go(3'b111, 32'h1, 32'h2);
        no_done("rsv_no_done", 4);

        go(3'b000, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.a     = 32'hDEAD;
        @(posedge clk);
        #2 bus.start = 1'b0;
        wait_done("busy_mtlo");
        check("busy_mtlo_lo", bus.lo, 32'd42);
        check("busy_mtlo_hi", bus.hi, 32'd0);

        go(3'b100, 32'hA, 32'h0);
        go(3'b101, 32'hB, 32'h0);
        go(3'b000, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #2 bus.flush = 1'b1;
        @(posedge clk);
        #2 bus.flush = 1'b0;
        check("flush_ready", 32'(bus.ready), 32'd1);
        check("flush_hi", bus.hi, 32'hA);
        check("flush_lo", bus.lo, 32'hB);
        no_done("flush_no_done", 40);

        go(3'b000, 32'd2, 32'd3);
        wait_done("b2b_a");
        check("b2b_a_lo", bus.lo, 32'd6);
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #2;
        e0 = cyc;
        bus.start = 1'b0;
        wait_done("b2b_b");
        check("b2b_b_lo", bus.lo, 32'd14);
        check("b2b_b_hi", bus.hi, 32'd2);

        vop[0] = 3'b000; va[0] = 32'h7FFF_FFFF; vb[0] = 32'h8000_0000;
        vop[1] = 3'b001; va[1] = 32'h8000_0001; vb[1] = 32'h0001_0003;
        vop[2] = 3'b010; va[2] = 32'd5;         vb[2] = 32'hFFFF_FFFD;
        vop[3] = 3'b010; va[3] = 32'h0;         vb[3] = 32'h0;
        vop[4] = 3'b011; va[4] = 32'hFFFF_FFFF; vb[4] = 32'd1;
        vop[5] = 3'b010; va[5] = 32'h8000_0000; vb[5] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            go(vop[i], va[i], vb[i]);
            wait_done($sformatf("vec%0d", i));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide execution stage downstream of the register file.
- Consumes the two register read operands (RS/RT values) and produces the MIPS HI/LO architectural registers.
- HI/LO are read back by MFHI/MFLO through the writeback mux.
- Frees the single-cycle ALU from 32-bit multiply/divide; the controller stalls on `ready`.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when ready=1
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
a  in  WIDTH  operand RS (multiplicand / dividend / MTHI-MTLO source)
b  in  WIDTH  operand RT (multiplier / divisor)
flush  in  1  cancel any in-flight operation
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse: HI/LO just updated by mult/div
div_by_zero  out  1  valid with done; divisor was zero
hi  out  WIDTH  HI register (MFHI source)
lo  out  WIDTH  LO register (MFLO source)

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, ready=1, done=0, div_by_zero=0, state=IDLE, iteration counter=0. Takes effect immediately, mid-operation included; no partial result is written.
- States are IDLE, BUSY and FIN.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) <= a at that edge E0.
  - No done pulse; ready stays 1.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: at E0 the block latches operands and goes to BUSY.
  - Signed ops convert operands to magnitudes and record signs; unsigned ops use operands as-is.
  - counter <= 0; ready <= 0.
- BUSY: one shift-add (multiply) or one restoring shift-subtract (divide) step per edge.
  - Steps occur at edges E1..E32; after step WIDTH, state goes to FIN.
- FIN, edge E33:
  - Multiply: {hi,lo} <= 64-bit product, negated if the operand signs differ (signed only).
  - Divide: lo <= quotient, hi <= remainder.
  - Signed divide: quotient sign = sa^sb; remainder takes the dividend sign.
  - Then done <= 1, ready <= 1, state goes to IDLE.
- Latency: hi/lo valid and done=1 in the cycle after E33, i.e. 33 cycles after the start edge.
  - A new start may be accepted in that same done cycle.
- Divide by zero: skip the steps.
  - hi <= a, lo <= all-ones, div_by_zero <= 1.
  - Still uses the full 33-cycle latency, so timing is data-independent.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is natural wrap; no flag.
- start while ready=0: ignored; no queueing.
- Reserved op: ignored; stays IDLE.
- flush=1 in BUSY or FIN: next edge returns to IDLE with ready=1.
  - hi/lo unchanged, no done.
  - flush has priority over the FIN write.
- flush with start in IDLE: start is ignored.
- done and div_by_zero: both are 1-cycle pulses, deasserted otherwise.
- hi/lo are stable except on the E0 MTHI/MTLO write and the FIN write.

Test Plan:
- Reset mid-BUSY from previous hi=0x12345678: assert rst at cycle 10 -> immediately hi=lo=0, ready=1; no done follows.
- MULT a=0xFFFFFFFD (-3), b=5 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=7, b=0 -> at cycle 33 done=1, div_by_zero=1, hi=7, lo=0xFFFFFFFF.
- MTHI a=0xCAFEF00D -> hi=0xCAFEF00D the next cycle, ready stays 1, done stays 0. Start MULT, pulse start with op=MTLO at cycle 5 -> ignored, lo=product only.
- Flush at cycle 10 of MULT with prior hi=0xA, lo=0xB -> ready=1 next cycle, hi=0xA, lo=0xB, no done. Back-to-back start in the done cycle -> accepted; second done arrives 33 cycles later.
